// File: rtl/simd_carry_mask_gen_pkg.sv
// simd_carry_mask_gen_pkg: shared vector constants, sew decoding and FSM states
package simd_carry_mask_gen_pkg;

    localparam int MIN_W = 8;
    localparam int MAX_W = 64;
    localparam int RATIO = MAX_W / MIN_W;
    localparam int SEW_W = $clog2(RATIO) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    // One-hot sew code to shift amount k (element width MAX>>k, 2^k elements);
    // the lowest set bit wins so a malformed code still decodes deterministically.
    function automatic int sew_to_k(input logic [31:0] s);
        int k = 0;
        for (int i = 31; i >= 0; i--) if (s[i]) k = i;
        return k;
    endfunction

endpackage

// File: rtl/simd_carry_mask_gen_chain.sv
// simd_carry_chain: per-element carry/borrow-out of a packed operand beat
module simd_carry_chain
    import simd_carry_mask_gen_pkg::*;
#(
    parameter int MIN_WIDTH = MIN_W,
    parameter int MAX_WIDTH = MAX_W,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1
) (
    input  logic [SEW_WIDTH-1:0]             sew_i,
    input  logic                             sub_i,
    input  logic [MAX_WIDTH/MIN_WIDTH-1:0]   cin_i,
    input  logic [MAX_WIDTH-1:0]             opa_i,
    input  logic [MAX_WIDTH-1:0]             opb_i,
    output logic [MAX_WIDTH/MIN_WIDTH-1:0]   co_o
);
    localparam int R = MAX_WIDTH / MIN_WIDTH;

    logic [R-1:0] cand [SEW_WIDTH];
    int sk;

    // Every element width is evaluated in parallel; subtraction reuses the adder
    // as a + ~b + ~bin, and the borrow is the inverted carry.
    for (genvar k = 0; k < SEW_WIDTH; k++) begin : g_k
        localparam int W = MAX_WIDTH >> k;
        logic [(1<<k)-1:0] c;
        for (genvar e = 0; e < (1 << k); e++) begin : g_e
            logic [W:0] s;
            assign s = {1'b0, opa_i[e*W +: W]}
                     + {1'b0, sub_i ? ~opb_i[e*W +: W] : opb_i[e*W +: W]}
                     + {{W{1'b0}}, sub_i ^ cin_i[e]};
            assign c[e] = sub_i ^ s[W];
        end
        assign cand[k] = R'(c);
    end

    assign sk = sew_to_k(32'(sew_i));

    // Pick the result row of the selected element width; unused upper bits stay 0.
    always_comb begin
        co_o = '0;
        for (int i = 0; i < SEW_WIDTH; i++) if (i == sk) co_o = cand[i];
    end

endmodule

// File: rtl/simd_carry_mask_gen.sv
// simd_carry_mask_gen: packs per-element carry/borrow-outs of a beat group into a mask
module simd_carry_mask_gen
    import simd_carry_mask_gen_pkg::*;
#(
    parameter int MIN_WIDTH = MIN_W,
    parameter int MAX_WIDTH = MAX_W,
    parameter int SEW_WIDTH = $clog2(MAX_WIDTH / MIN_WIDTH) + 1,
    parameter int MASK_BITS = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             last_i,
    input  logic                             sub,
    input  logic                             use_carry,
    input  logic [SEW_WIDTH-1:0]             sew,
    input  logic [MAX_WIDTH/MIN_WIDTH-1:0]   carry_i,
    input  logic [MAX_WIDTH-1:0]             opA,
    input  logic [MAX_WIDTH-1:0]             opB,
    input  logic                             ready_i,
    output logic                             valid_o,
    output logic [MASK_BITS-1:0]             mask_o,
    output logic [$clog2(MASK_BITS):0]       count_o,
    output logic                             overflow_o
);
    localparam int R  = MAX_WIDTH / MIN_WIDTH;
    localparam int CW = $clog2(MASK_BITS) + 1;

    state_e               state_q, state_d;
    logic [MASK_BITS-1:0] mask_q, mask_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [SEW_WIDTH-1:0] sew_q, sew_d, sew_e;
    logic                 sub_q, sub_d, sub_e;
    logic                 uc_q, uc_d, uc_e;
    logic [R-1:0]         co;
    logic                 acc, first;
    int                   n, total;

    assign ready_o    = state_q != DONE;
    assign valid_o    = state_q == DONE;
    assign acc        = valid_i && ready_o;
    assign first      = state_q == IDLE;
    assign sew_e      = first ? sew : sew_q;
    assign sub_e      = first ? sub : sub_q;
    assign uc_e       = first ? use_carry : uc_q;
    assign mask_o     = mask_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    simd_carry_chain #(
        .MIN_WIDTH(MIN_WIDTH),
        .MAX_WIDTH(MAX_WIDTH),
        .SEW_WIDTH(SEW_WIDTH)
    ) u_chain (
        .sew_i(sew_e),
        .sub_i(sub_e),
        .cin_i(carry_i & {R{uc_e}}),
        .opa_i(opA),
        .opb_i(opB),
        .co_o (co)
    );

    // Next state: append accepted beats at count (bits past MASK_BITS fall off the
    // shift), saturate count, and clear the group on the output handshake.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        sew_d   = sew_q;
        sub_d   = sub_q;
        uc_d    = uc_q;
        n       = 1 << sew_to_k(32'(sew_e));
        total   = int'(count_q) + n;
        if (acc) begin
            if (first) begin
                sew_d = sew;
                sub_d = sub;
                uc_d  = use_carry;
            end
            mask_d  = mask_q | (MASK_BITS'(co) << count_q);
            count_d = total > MASK_BITS ? CW'(MASK_BITS) : CW'(total);
            ovf_d   = ovf_q | (total > MASK_BITS);
            state_d = last_i ? DONE : ACCUM;
        end else if (valid_o && ready_i) begin
            state_d = IDLE;
            mask_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and group registers; reset aborts any group in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            sew_q   <= '0;
            sub_q   <= 1'b0;
            uc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sew_q   <= sew_d;
            sub_q   <= sub_d;
            uc_q    <= uc_d;
        end
    end

endmodule

// File: tb/tb_simd_carry_mask_gen.sv
// tb_simd_carry_mask_gen: randomized and directed bench against a bit-queue reference model
module tb_simd_carry_mask_gen;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, last_i, sub, use_carry, ready_i, valid_o, overflow_o;
    logic [3:0]  sew;
    logic [7:0]  carry_i;
    logic [63:0] opA, opB, mask_o;
    logic [6:0]  count_o;

    int vectors = 0;
    int miscompares = 0;

    bit         q[$];
    bit         g_open = 1'b0;
    logic [3:0] g_sew;
    logic       g_sub, g_uc;

    always #5 clk = ~clk;

    simd_carry_mask_gen dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
        .sub(sub), .use_carry(use_carry), .sew(sew), .carry_i(carry_i), .opA(opA), .opB(opB),
        .ready_i(ready_i), .valid_o(valid_o), .mask_o(mask_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    // Reference: each element is an unsigned number; carry means the true sum exceeds
    // the element range, borrow means the subtrahend plus borrow-in exceeds the minuend.
    function automatic void model_beat(input logic [63:0] a, input logic [63:0] b, input logic [7:0] c);
        int k = 0;
        int w;
        logic [65:0] ea, eb, lim;
        logic ci;
        for (int i = 0; i < 4; i++) if (g_sew[i]) k = i;
        w = 64 >> k;
        lim = (66'd1 << w) - 66'd1;
        for (int e = 0; e < (1 << k); e++) begin
            ea = 66'(a >> (e * w)) & lim;
            eb = 66'(b >> (e * w)) & lim;
            ci = g_uc & c[e];
            if (!g_sub) q.push_back((ea + eb + 66'(ci)) > lim);
            else q.push_back(ea < (eb + 66'(ci)));
        end
    endfunction

    function automatic logic [63:0] exp_mask();
        logic [63:0] m = '0;
        for (int i = 0; i < q.size() && i < 64; i++) m[i] = q[i];
        return m;
    endfunction

    function automatic int exp_count();
        return q.size() > 64 ? 64 : q.size();
    endfunction

    task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [7:0] c,
                        input logic [3:0] s, input logic sb, input logic uc, input logic lst);
        if (!g_open) begin
            g_open = 1'b1;
            g_sew  = s;
            g_sub  = sb;
            g_uc   = uc;
        end
        model_beat(a, b, c);
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL beat_ready: got %b want 1", ready_o);
        end
        valid_i = 1'b1; opA = a; opB = b; carry_i = c; sew = s; sub = sb; use_carry = uc; last_i = lst;
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic finish_group();
        vectors += 5;
        if (valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL done_valid: got %b want 1", valid_o);
        end
        if (ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL done_ready: got %b want 0", ready_o);
        end
        if (mask_o !== exp_mask()) begin
            miscompares++;
            $display("FAIL mask: got %h want %h", mask_o, exp_mask());
        end
        if (count_o !== 7'(exp_count())) begin
            miscompares++;
            $display("FAIL count: got %0d want %0d", count_o, exp_count());
        end
        if (overflow_o !== (q.size() > 64)) begin
            miscompares++;
            $display("FAIL overflow: got %b want %b", overflow_o, q.size() > 64);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        vectors++;
        if ({valid_o, ready_o, mask_o, count_o, overflow_o} !== {1'b0, 1'b1, 64'h0, 7'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clear: got v=%b r=%b m=%h c=%0d o=%b want v=0 r=1 m=0 c=0 o=0",
                     valid_o, ready_o, mask_o, count_o, overflow_o);
        end
        g_open = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if ({valid_o, ready_o, mask_o, count_o, overflow_o} !== {1'b0, 1'b1, 64'h0, 7'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got v=%b r=%b m=%h c=%0d o=%b", valid_o, ready_o, mask_o, count_o, overflow_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got r=%b v=%b want r=1 v=0", ready_o, valid_o);
        end
    endtask

    task automatic test_directed();
        beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b1);
        vectors += 2;
        if (mask_o !== 64'hFF) begin miscompares++; $display("FAIL bytes_mask: got %h want ff", mask_o); end
        if (count_o !== 7'd8) begin miscompares++; $display("FAIL bytes_count: got %0d want 8", count_o); end
        finish_group();
        beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b1);
        vectors += 2;
        if (mask_o !== 64'h1) begin miscompares++; $display("FAIL dword_carry: got %h want 1", mask_o); end
        if (count_o !== 7'd1) begin miscompares++; $display("FAIL dword_count: got %0d want 1", count_o); end
        finish_group();
        beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (mask_o !== 64'h0) begin miscompares++; $display("FAIL dword_nocarry: got %h want 0", mask_o); end
        finish_group();
        beat(64'h0, 64'h0001_0001_0001_0001, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (mask_o !== 64'hF) begin miscompares++; $display("FAIL half_borrow: got %h want f", mask_o); end
        finish_group();
        beat(64'h0, 64'h0, 8'b0101, 4'b0100, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (mask_o !== 64'h5) begin miscompares++; $display("FAIL half_bin: got %h want 5", mask_o); end
        finish_group();
        beat(64'hFF, 64'h01, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0);
        beat(64'hFF00_0000_0000_0000, 64'h0100_0000_0000_0000, 8'h00, 4'b0001, 1'b1, 1'b1, 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b1);
        vectors += 2;
        if (mask_o !== 64'hFF8001) begin miscompares++; $display("FAIL three_beats: got %h want ff8001", mask_o); end
        if (count_o !== 7'd24) begin miscompares++; $display("FAIL three_count: got %0d want 24", count_o); end
        finish_group();
        for (int i = 0; i < 9; i++)
            beat(64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 8'h00, 4'b1000, 1'b0, 1'b0, i == 8);
        vectors += 3;
        if (mask_o !== '1) begin miscompares++; $display("FAIL ovf_mask: got %h want all ones", mask_o); end
        if (count_o !== 7'd64) begin miscompares++; $display("FAIL ovf_count: got %0d want 64", count_o); end
        if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        finish_group();
    endtask

    task automatic test_backpressure();
        logic [63:0] m;
        beat({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 4'b0010, 1'b1, 1'b1, 1'b0);
        beat({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 4'b1000, 1'b0, 1'b0, 1'b1);
        m = exp_mask();
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; opA = '1; opB = '1; sew = 4'b1000; last_i = 1'b1;
            vectors++;
            if ({valid_o, ready_o, mask_o, count_o, overflow_o} !== {1'b1, 1'b0, m, 7'(exp_count()), 1'b0}) begin
                miscompares++;
                $display("FAIL hold: got v=%b r=%b m=%h c=%0d o=%b want v=1 r=0 m=%h c=%0d o=0",
                         valid_o, ready_o, mask_o, count_o, overflow_o, m, exp_count());
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        finish_group();
    endtask

    task automatic test_reset_mid_group();
        beat({$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, 4'b1000, 1'b0, 1'b1, 1'b0);
        beat({$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, 4'b1000, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if ({valid_o, ready_o, mask_o, count_o, overflow_o} !== {1'b0, 1'b1, 64'h0, 7'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b r=%b m=%h c=%0d o=%b", valid_o, ready_o, mask_o, count_o, overflow_o);
        end
        @(negedge clk);
        rst = 1'b0;
        g_open = 1'b0;
        q.delete();
        beat({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 4'b0100, 1'b0, 1'b1, 1'b1);
        finish_group();
    endtask

    task automatic test_random();
        for (int g = 0; g < 40; g++) begin
            int nb = $urandom_range(1, 10);
            logic [3:0] s = 4'b1 << $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    opA = {$urandom, $urandom}; sew = 4'($urandom);
                    @(negedge clk);
                end
                beat({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                     b == 0 ? s : 4'b1 << $urandom_range(0, 3), 1'($urandom), 1'($urandom), b == nb - 1);
            end
            finish_group();
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; last_i = 1'b0; sub = 1'b0; use_carry = 1'b0; ready_i = 1'b0;
        sew = 4'b1000; carry_i = '0; opA = '0; opB = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
